systolic_operand_loader: RTL

Row-streaming operand loader for the systolic matrix-multiply array. It accepts matrix rows over a valid/ready stream, N rows of A followed by N rows of B, and assembles them into the packed A and B operand buses. It then issues a single-cycle `o_validInput` pulse to the array and holds the operands stable until the array returns `i_validResult`. It is the producer side of the array's `i_validInput`/`i_a`/`i_b` interface.

---
 rtl/systolic_operand_loader.sv | 74 +++++++
 1 files changed

// File: rtl/systolic_operand_loader.sv
// systolic_operand_loader: streams N A-rows then N B-rows into packed operand buses, pulses o_validInput, holds until i_validResult
//   i_clk/i_arst       clock, async active-high reset
//   i_rowValid/o_rowReady/i_rowData  row stream (element [j] = column j)
//   i_flush            sync abort back to A row 0, operands kept
//   i_validResult      array result-valid, releases WAIT
//   o_a/o_b            operand matrices [row][col]
//   o_validInput       one-cycle start pulse (FIRE)
//   o_rowCount/o_loadingB/o_busy  status
module systolic_operand_loader #(
  parameter int N  = 32,
  parameter int DW = 8
) (
  input  logic                                i_clk,
  input  logic                                i_arst,
  input  logic                                i_rowValid,
  output logic                                o_rowReady,
  input  logic signed [N-1:0][DW-1:0]         i_rowData,
  input  logic                                i_flush,
  input  logic                                i_validResult,
  output logic signed [N-1:0][N-1:0][DW-1:0]  o_a,
  output logic signed [N-1:0][N-1:0][DW-1:0]  o_b,
  output logic                                o_validInput,
  output logic [$clog2(N)-1:0]                o_rowCount,
  output logic                                o_loadingB,
  output logic                                o_busy
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {LOAD_A, LOAD_B, FIRE, WAIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0][N-1:0][DW-1:0] a_q, a_d, b_q, b_d;
  logic accept, last;
  assign o_rowReady   = (state_q == LOAD_A || state_q == LOAD_B) && !i_flush;
  assign accept       = i_rowValid && o_rowReady;
  assign last         = cnt_q == CW'(N - 1);
  assign o_validInput = state_q == FIRE;
  assign o_loadingB   = state_q == LOAD_B;
  assign o_busy       = state_q == FIRE || state_q == WAIT;
  assign o_rowCount   = cnt_q;
  assign o_a          = a_q;
  assign o_b          = b_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    if (i_flush) begin
      state_d = LOAD_A;
      cnt_d   = '0;
    end else begin
      if (accept) begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (state_q == LOAD_A) a_d[cnt_q] = i_rowData;
        else b_d[cnt_q] = i_rowData;
        if (last) state_d = state_q == LOAD_A ? LOAD_B : FIRE;
      end
      if (state_q == FIRE) state_d = WAIT;
      if (state_q == WAIT && i_validResult) state_d = LOAD_A;
    end
  end
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end
endmodule
